// File: rtl/pkt_class_pkg.sv
// Shared types, TLP header codes and field offsets for the packet classifier.
package pkt_class_pkg;

  typedef enum logic [2:0] {
    PU_MEM_REQ = 3'd0,
    PU_ATOMIC  = 3'd1,
    PU_CPL     = 3'd2,
    DM_MEM_REQ = 3'd3,
    DM_CPL     = 3'd4,
    UNKNOWN    = 3'd5
  } pkt_class_e;

  localparam int unsigned NUM_CLASSES = 6;

  localparam logic [7:0] FMT_TYPE_MRD32      = 8'h00;
  localparam logic [7:0] FMT_TYPE_MRD64      = 8'h20;
  localparam logic [7:0] FMT_TYPE_MWR32      = 8'h40;
  localparam logic [7:0] FMT_TYPE_MWR64      = 8'h60;
  localparam logic [7:0] FMT_TYPE_FETCHADD32 = 8'h4C;
  localparam logic [7:0] FMT_TYPE_FETCHADD64 = 8'h6C;
  localparam logic [7:0] FMT_TYPE_SWAP32     = 8'h4D;
  localparam logic [7:0] FMT_TYPE_SWAP64     = 8'h6D;
  localparam logic [7:0] FMT_TYPE_CAS32      = 8'h4E;
  localparam logic [7:0] FMT_TYPE_CAS64      = 8'h6E;
  localparam logic [7:0] FMT_TYPE_CPL        = 8'h0A;
  localparam logic [7:0] FMT_TYPE_CPLD       = 8'h4A;

  localparam int unsigned HDR_W              = 128;
  localparam int unsigned HDR_LEN_LSB        = 0;
  localparam int unsigned HDR_LEN_W          = 10;
  localparam int unsigned HDR_FMT_TYPE_LSB   = 24;
  localparam int unsigned HDR_TAG_LSB        = 40;
  localparam int unsigned HDR_REQ_ID_LSB     = 48;
  localparam int unsigned HDR_ADDR_HI_LSB    = 64;
  localparam int unsigned HDR_ADDR32_LSB     = 66;
  localparam int unsigned HDR_ADDR64_LO_LSB  = 98;
  localparam int unsigned FMT_4DW_BIT        = 5;

  function automatic logic is_mem_req(input logic [7:0] fmt_type);
    return (fmt_type == FMT_TYPE_MRD32) || (fmt_type == FMT_TYPE_MRD64) ||
           (fmt_type == FMT_TYPE_MWR32) || (fmt_type == FMT_TYPE_MWR64);
  endfunction

  function automatic logic is_fetchadd_swap(input logic [7:0] fmt_type);
    return (fmt_type == FMT_TYPE_FETCHADD32) || (fmt_type == FMT_TYPE_FETCHADD64) ||
           (fmt_type == FMT_TYPE_SWAP32)     || (fmt_type == FMT_TYPE_SWAP64);
  endfunction

  function automatic logic is_cas(input logic [7:0] fmt_type);
    return (fmt_type == FMT_TYPE_CAS32) || (fmt_type == FMT_TYPE_CAS64);
  endfunction

  function automatic pkt_class_e decode_class(input logic [7:0] fmt_type, input logic dm);
    pkt_class_e cls;
    cls = UNKNOWN;
    if (dm) begin
      if (is_mem_req(fmt_type))            cls = DM_MEM_REQ;
      else if (fmt_type == FMT_TYPE_CPLD)  cls = DM_CPL;
    end else begin
      if (is_mem_req(fmt_type))                                       cls = PU_MEM_REQ;
      else if (is_fetchadd_swap(fmt_type) || is_cas(fmt_type))        cls = PU_ATOMIC;
      else if (fmt_type == FMT_TYPE_CPL || fmt_type == FMT_TYPE_CPLD) cls = PU_CPL;
    end
    return cls;
  endfunction

  // Operand size is fixed by the atomic opcode; anything else cannot be executed.
  function automatic logic atomic_len_bad(input logic [7:0] fmt_type,
                                          input logic [HDR_LEN_W-1:0] len_dw);
    logic bad;
    bad = 1'b0;
    if (is_fetchadd_swap(fmt_type))
      bad = !(len_dw == 10'd1 || len_dw == 10'd2);
    else if (is_cas(fmt_type))
      bad = !(len_dw == 10'd2 || len_dw == 10'd4 || len_dw == 10'd8);
    return bad;
  endfunction

endpackage

// File: rtl/pkt_class_stats.sv
// Saturating per-class packet counters; one counter per pkt_class_e value.
module pkt_class_stats
  import pkt_class_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cnt_en_i,
  input  pkt_class_e                   class_i,
  output logic [NUM_CLASSES*CNT_W-1:0] stat_cnt_o
);

  logic [CNT_W-1:0] cnt_q [NUM_CLASSES];
  logic [CNT_W-1:0] cnt_d [NUM_CLASSES];

  always_comb begin
    for (int i = 0; i < NUM_CLASSES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_en_i && (int'(class_i) == i) && (cnt_q[i] != '1))
        cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CLASSES; i++) stat_cnt_o[i*CNT_W +: CNT_W] = cnt_q[i];
  end

endmodule

// File: rtl/tlp_pkt_classifier.sv
// Single-register AXI-Stream stage that classifies TLPs on their SOP beat.
// Optional statistics bank enabled by defining PKT_CLASS_STATS_EN.
module tlp_pkt_classifier
  import pkt_class_pkg::*;
#(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_tvalid,
  output logic                 in_tready,
  input  logic [DATA_W-1:0]    in_tdata,
  input  logic                 in_tlast,
  input  logic                 in_tuser_dm,
  output logic                 out_tvalid,
  input  logic                 out_tready,
  output logic [DATA_W-1:0]    out_tdata,
  output logic                 out_tlast,
  output logic                 out_sop,
  output pkt_class_e           out_class,
  output logic [63:0]          out_addr,
  output logic [12:0]          out_len_bytes,
  output logic [7:0]           out_tag,
  output logic [15:0]          out_req_id,
  output logic                 out_malformed,
  output logic [6*CNT_W-1:0]   stat_cnt
);

  logic [7:0]           fmt_type;
  logic [HDR_LEN_W-1:0] len_dw;
  pkt_class_e           cls_dec;
  logic [63:0]          addr_dec;
  logic [12:0]          len_dec;
  logic                 mal_dec;
  logic                 load;

  logic                 valid_q,  valid_d;
  logic [DATA_W-1:0]    data_q,   data_d;
  logic                 last_q,   last_d;
  logic                 osop_q,   osop_d;
  pkt_class_e           class_q,  class_d;
  logic [63:0]          addr_q,   addr_d;
  logic [12:0]          len_q,    len_d;
  logic [7:0]           tag_q,    tag_d;
  logic [15:0]          req_id_q, req_id_d;
  logic                 mal_q,    mal_d;
  logic                 sop_q,    sop_d;

  assign fmt_type = in_tdata[HDR_FMT_TYPE_LSB +: 8];
  assign len_dw   = in_tdata[HDR_LEN_LSB +: HDR_LEN_W];
  assign cls_dec  = decode_class(fmt_type, in_tuser_dm);

  always_comb begin
    addr_dec = '0;
    if (cls_dec == PU_MEM_REQ || cls_dec == DM_MEM_REQ || cls_dec == PU_ATOMIC) begin
      if (fmt_type[FMT_4DW_BIT])
        addr_dec = {in_tdata[HDR_ADDR_HI_LSB +: 32], in_tdata[HDR_ADDR64_LO_LSB +: 30], 2'b00};
      else
        addr_dec = {32'h0, in_tdata[HDR_ADDR32_LSB +: 30], 2'b00};
    end
  end

  // A zero length field encodes the maximum of 1024 DW.
  assign len_dec = (len_dw == '0) ? 13'h1000 : {1'b0, len_dw, 2'b00};
  assign mal_dec = (cls_dec == PU_ATOMIC) && atomic_len_bad(fmt_type, len_dw);

  assign in_tready = !valid_q || out_tready;
  assign load      = in_tvalid && in_tready;

  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    last_d   = last_q;
    osop_d   = osop_q;
    class_d  = class_q;
    addr_d   = addr_q;
    len_d    = len_q;
    tag_d    = tag_q;
    req_id_d = req_id_q;
    mal_d    = mal_q;
    sop_d    = sop_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_tdata;
      last_d  = in_tlast;
      osop_d  = sop_q;
      sop_d   = in_tlast;
      if (sop_q) begin
        class_d  = cls_dec;
        addr_d   = addr_dec;
        len_d    = len_dec;
        tag_d    = in_tdata[HDR_TAG_LSB +: 8];
        req_id_d = in_tdata[HDR_REQ_ID_LSB +: 16];
        mal_d    = mal_dec;
      end
    end else if (out_tready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
      osop_q   <= 1'b0;
      class_q  <= UNKNOWN;
      addr_q   <= '0;
      len_q    <= '0;
      tag_q    <= '0;
      req_id_q <= '0;
      mal_q    <= 1'b0;
      sop_q    <= 1'b1;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      last_q   <= last_d;
      osop_q   <= osop_d;
      class_q  <= class_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      tag_q    <= tag_d;
      req_id_q <= req_id_d;
      mal_q    <= mal_d;
      sop_q    <= sop_d;
    end
  end

  assign out_tvalid    = valid_q;
  assign out_tdata     = data_q;
  assign out_tlast     = last_q;
  assign out_sop       = osop_q;
  assign out_class     = class_q;
  assign out_addr      = addr_q;
  assign out_len_bytes = len_q;
  assign out_tag       = tag_q;
  assign out_req_id    = req_id_q;
  assign out_malformed = mal_q;

`ifdef PKT_CLASS_STATS_EN
  pkt_class_stats #(
    .CNT_W (CNT_W)
  ) u_stats (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt_en_i   (valid_q && out_tready && osop_q),
    .class_i    (class_q),
    .stat_cnt_o (stat_cnt)
  );
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_tlp_pkt_classifier.sv
// Scoreboard bench for tlp_pkt_classifier: directed TLP headers, backpressure, mid-packet reset.
module tb_tlp_pkt_classifier;
  import pkt_class_pkg::*;

  localparam int DATA_W = 256;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_tvalid, in_tready, in_tlast, in_tuser_dm;
  logic [DATA_W-1:0] in_tdata;
  logic              out_tvalid, out_tready, out_tlast, out_sop, out_malformed;
  logic [DATA_W-1:0] out_tdata;
  pkt_class_e        out_class;
  logic [63:0]       out_addr;
  logic [12:0]       out_len_bytes;
  logic [7:0]        out_tag;
  logic [15:0]       out_req_id;
  logic [6*CNT_W-1:0] stat_cnt;

  tlp_pkt_classifier #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
    .in_tlast(in_tlast), .in_tuser_dm(in_tuser_dm),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
    .out_tlast(out_tlast), .out_sop(out_sop), .out_class(out_class),
    .out_addr(out_addr), .out_len_bytes(out_len_bytes), .out_tag(out_tag),
    .out_req_id(out_req_id), .out_malformed(out_malformed), .stat_cnt(stat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              sop;
    logic [2:0]        cls;
    logic [63:0]       addr;
    logic [12:0]       len;
    logic [7:0]        tag;
    logic [15:0]       rid;
    logic              mal;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_beat = 0;

  function automatic logic [DATA_W-1:0] hdr(input logic [31:0] dw0, dw1, dw2, dw3);
    logic [DATA_W-1:0] d;
    d = {(DATA_W/32){dw0 ^ 32'h5A5A_0F0F}};
    d[127:0] = {dw3, dw2, dw1, dw0};
    return d;
  endfunction

  function automatic exp_t mk(input logic [DATA_W-1:0] d, input logic last, sop,
                              input logic [2:0] cls, input logic [63:0] addr,
                              input logic [12:0] len, input logic [7:0] tag,
                              input logic [15:0] rid, input logic mal);
    exp_t e;
    e.data = d; e.last = last; e.sop = sop; e.cls = cls; e.addr = addr;
    e.len = len; e.tag = tag; e.rid = rid; e.mal = mal;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Caller is positioned just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [DATA_W-1:0] d, input logic last, input logic dm, input exp_t e);
    int budget;
    in_tvalid = 1'b1; in_tdata = d; in_tlast = last; in_tuser_dm = dm;
    budget = 0;
    @(negedge clk);
    while (!in_tready && budget < 100) begin
      budget++;
      @(negedge clk);
    end
    if (!in_tready) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: in_tready stuck low for %0d cycles", budget);
    end else begin
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    in_tvalid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int b;
    b = 0;
    while (sb_q.size() != 0 && b < 200) begin
      b++;
      @(negedge clk);
    end
    if (sb_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL %s_drain: %0d beats never emerged", name, sb_q.size());
      sb_q.delete();
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_tvalid && out_tready) begin
      n_vec++;
      n_beat++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL beat%0d_unexpected: output beat with empty scoreboard, data %h", n_beat, out_tdata[63:0]);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (out_tdata !== e.data || out_tlast !== e.last || out_sop !== e.sop ||
            out_class !== e.cls || out_addr !== e.addr || out_len_bytes !== e.len ||
            out_tag !== e.tag || out_req_id !== e.rid || out_malformed !== e.mal) begin
          n_err++;
          $display("FAIL beat%0d: got/exp data %h/%h last %b/%b sop %b/%b cls %0d/%0d addr %h/%h len %0d/%0d tag %h/%h rid %h/%h mal %b/%b",
                   n_beat, out_tdata[63:0], e.data[63:0], out_tlast, e.last, out_sop, e.sop,
                   out_class, e.cls, out_addr, e.addr, out_len_bytes, e.len,
                   out_tag, e.tag, out_req_id, e.rid, out_malformed, e.mal);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] d, b1, b2, b3;
    rst_n = 1'b0; in_tvalid = 1'b0; in_tdata = '0; in_tlast = 1'b0;
    in_tuser_dm = 1'b0; out_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(out_tvalid), 64'd0);
    chk("rst_sop",    64'(out_sop),    64'd0);
    chk("rst_class",  64'(out_class),  64'd5);
    chk("rst_addr",   out_addr,        64'd0);
    chk("rst_data",   out_tdata[63:0], 64'd0);
    chk("rst_tready", 64'(in_tready),  64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    d = hdr(32'h6000_0002, 32'h1234_56FF, 32'h0000_0001, 32'hBAAD_BEE8);
    send(d, 1'b1, 1'b0, mk(d, 1, 1, 3'd0, 64'h0000_0001_BAAD_BEE8, 13'd8, 8'h56, 16'h1234, 0));
    d = hdr(32'h0000_0000, 32'hABCD_0100, 32'h8000_0010, 32'h0);
    send(d, 1'b1, 1'b1, mk(d, 1, 1, 3'd3, 64'h8000_0010, 13'd4096, 8'h01, 16'hABCD, 0));
    d = hdr(32'h4C00_0001, 32'h1111_2200, 32'h0000_2000, 32'h0);
    send(d, 1'b1, 1'b1, mk(d, 1, 1, 3'd5, 64'h0, 13'd4, 8'h22, 16'h1111, 0));
    d = hdr(32'h4E00_0003, 32'h2222_3300, 32'h0000_1000, 32'h0);
    send(d, 1'b1, 1'b0, mk(d, 1, 1, 3'd1, 64'h1000, 13'd12, 8'h33, 16'h2222, 1));
    d = hdr(32'h4E00_0004, 32'h2222_3300, 32'h0000_1000, 32'h0);
    send(d, 1'b1, 1'b0, mk(d, 1, 1, 3'd1, 64'h1000, 13'd16, 8'h33, 16'h2222, 0));
    d = hdr(32'h6C00_0004, 32'h0F0F_0A00, 32'h0000_0002, 32'h0000_0010);
    send(d, 1'b1, 1'b0, mk(d, 1, 1, 3'd1, 64'h0000_0002_0000_0010, 13'd16, 8'h0A, 16'h0F0F, 1));
    d = hdr(32'h4D00_0002, 32'h0F0F_0B00, 32'hFFFF_FFFC, 32'h0);
    send(d, 1'b1, 1'b0, mk(d, 1, 1, 3'd1, 64'hFFFF_FFFC, 13'd8, 8'h0B, 16'h0F0F, 0));
    d = hdr(32'h0A00_0000, 32'h3333_4400, 32'h1234_5678, 32'h0);
    send(d, 1'b1, 1'b0, mk(d, 1, 1, 3'd2, 64'h0, 13'd4096, 8'h44, 16'h3333, 0));
    d = hdr(32'h4A00_0001, 32'h5555_6600, 32'h1234_5678, 32'h0);
    send(d, 1'b1, 1'b1, mk(d, 1, 1, 3'd4, 64'h0, 13'd4, 8'h66, 16'h5555, 0));
    d = hdr(32'h7F00_0001, 32'h6666_7700, 32'hFFFF_FFF0, 32'h0);
    send(d, 1'b1, 1'b0, mk(d, 1, 1, 3'd5, 64'h0, 13'd4, 8'h77, 16'h6666, 0));
    wait_empty("directed");

    // Three-beat completion under 5 cycles of downstream stall.
    b1 = hdr(32'h4A00_0010, 32'h0100_0040, 32'h5555_5555, 32'h6666_6666);
    b2 = {(DATA_W/32){32'hC0DE_0002}};
    b3 = {(DATA_W/32){32'hC0DE_0003}};
    out_tready = 1'b0;
    fork
      begin
        send(b1, 1'b0, 1'b0, mk(b1, 0, 1, 3'd2, 64'h0, 13'd64, 8'h00, 16'h0100, 0));
        send(b2, 1'b0, 1'b0, mk(b2, 0, 0, 3'd2, 64'h0, 13'd64, 8'h00, 16'h0100, 0));
        send(b3, 1'b1, 1'b0, mk(b3, 1, 0, 3'd2, 64'h0, 13'd64, 8'h00, 16'h0100, 0));
      end
    join_none
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_tready", 64'(in_tready),  64'd0);
      chk("bp_tvalid",    64'(out_tvalid), 64'd1);
      chk("bp_hold_data", out_tdata[63:0], b1[63:0]);
      chk("bp_hold_sop",  64'(out_sop),    64'd1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_tready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    wait_empty("backpressure");

    // Reset lands while beat 1 of a 3-beat write is sitting in the output register.
    d = hdr(32'h4000_0001, 32'h7777_8800, 32'h0000_4000, 32'h0);
    send(d, 1'b0, 1'b0, mk(d, 0, 1, 3'd0, 64'h4000, 13'd4, 8'h88, 16'h7777, 0));
    rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", 64'(out_tvalid), 64'd0);
    chk("midrst_class",  64'(out_class),  64'd5);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    d = hdr(32'h6000_0001, 32'h9999_AA00, 32'h0000_0000, 32'h0000_0100);
    send(d, 1'b1, 1'b0, mk(d, 1, 1, 3'd0, 64'h100, 13'd4, 8'hAA, 16'h9999, 0));
    wait_empty("post_reset");

`ifdef PKT_CLASS_STATS_EN
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      d = hdr(32'h0A00_0001, 32'h0001_0200 + 32'(i), 32'h0, 32'h0);
      send(d, 1'b1, 1'b0, mk(d, 1, 1, 3'd2, 64'h0, 13'd4, 8'h02, 16'h0001, 0));
    end
    wait_empty("stats");
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 6; c++)
      chk($sformatf("stat_cnt%0d", c), 64'(stat_cnt[c*CNT_W +: CNT_W]), (c == 2) ? 64'hF : 64'h0);
`else
    chk("stat_cnt_tied", 64'(stat_cnt), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
